ram_addr_pio_in: RTL and testbench



---
 rtl/ram_addr_pio_pkg.sv | 19 +
 rtl/ram_addr_pio_in_sync.sv | 27 ++
 rtl/ram_addr_pio_in.sv | 89 ++++++++
 tb/tb_ram_addr_pio_in.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ram_addr_pio_pkg.sv
// Shared register offsets, default width and the decoded bus access type
// used by the RAM write-address input PIO.
package ram_addr_pio_pkg;

   localparam int DATA_W_DFLT = 11;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_RSVD = 2'd1;
   localparam logic [1:0] REG_MASK = 2'd2;
   localparam logic [1:0] REG_CAP  = 2'd3;

   // One decoded Avalon-MM access for the current cycle
   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [1:0] addr;
   } bus_req_t;

endpackage

// File: rtl/ram_addr_pio_in_sync.sv
// Multi-flop synchronizer for a quasi-static or Gray-coded bus.
// Every stage clears on the synchronous active-low reset.
module pio_bit_sync #(
   parameter int WIDTH  = 11,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stg;

   // Shift the asynchronous input through STAGES flops
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stg <= '0;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/ram_addr_pio_in.sv
// Avalon-MM input PIO: synchronized RAM write address, edge capture with
// write-1-to-clear and a maskable level interrupt.
// Build option: RAM_ADDR_PIO_IRQ_EN enables IRQ_MASK and irq; without it
// irq is tied low and offset 2 reads zero.
module ram_addr_pio_in
   import ram_addr_pio_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DFLT,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] readdata,
   output logic              irq
);

   bus_req_t            req;
   logic [DATA_W-1:0]   sync_q, prev_q, chg, clr, cap, mask, rd_mux;
   logic [SYNC_STAGES:0] arm_pipe;
   logic                armed;

   assign req = '{rd: chipselect & ~read_n, wr: chipselect & ~write_n, addr: address};

   pio_bit_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_q)
   );

   // Previous sample for edge detect; arming ripples a 1 through a shift
   // register so edges are ignored until the reset zeros have flushed out
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q   <= '0;
         arm_pipe <= '0;
      end else begin
         prev_q   <= sync_q;
         arm_pipe <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign armed = arm_pipe[SYNC_STAGES];
   assign chg   = armed ? (sync_q ^ prev_q) : '0;
   assign clr   = (req.wr && req.addr == REG_CAP) ? writedata : '0;

   // Edge capture: clear first, then OR in new changes so a set wins
   always_ff @(posedge clk) begin
      if (!reset_n) cap <= '0;
      else          cap <= (cap & ~clr) | chg;
   end

`ifdef RAM_ADDR_PIO_IRQ_EN
   // Interrupt mask register
   always_ff @(posedge clk) begin
      if (!reset_n)                          mask <= '0;
      else if (req.wr && req.addr == REG_MASK) mask <= writedata;
   end

   assign irq = |(cap & mask);
`else
   assign mask = '0;
   assign irq  = 1'b0;
`endif

   // Read mux over the current register values (pre-write on a collision)
   always_comb begin
      rd_mux = '0;
      case (req.addr)
         REG_DATA: rd_mux = sync_q;
         REG_MASK: rd_mux = mask;
         REG_CAP:  rd_mux = cap;
         default:  rd_mux = '0;
      endcase
   end

   // Registered read data, held until the next read
   always_ff @(posedge clk) begin
      if (!reset_n)    readdata <= '0;
      else if (req.rd) readdata <= rd_mux;
   end

endmodule

// File: tb/tb_ram_addr_pio_in.sv
// Directed self-checking bench for ram_addr_pio_in (SYNC_STAGES = 2).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_ram_addr_pio_in;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, read_n, write_n;
   logic [10:0] writedata, in_port, readdata;
   logic        irq;

   int n_run  = 0;
   int n_fail = 0;

   ram_addr_pio_in #(.DATA_W(11), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [10:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      tick();
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
      write_n = 1'b1; writedata = 11'h000; in_port = 11'h5A5;

      // Reset with a non-zero input held
      repeat (4) tick();
      chk("rst_readdata", readdata, 11'h000);
      chk("rst_irq", 11'(irq), 11'h000);
      reset_n = 1'b1;
      repeat (4) tick();
      rd(2'd3); chk("arm_cap_clean", readdata, 11'h000);
      rd(2'd0); chk("data_after_rst", readdata, 11'h5A5);
      tick();   chk("readdata_hold", readdata, 11'h5A5);

      // Change 0x5A5 -> 0x000 is captured, then fully cleared
      in_port = 11'h000;
      repeat (5) tick();
      rd(2'd3); chk("cap_5a5", readdata, 11'h5A5);
      wr(2'd3, 11'h7FF);
      rd(2'd3); chk("cap_w1c_all", readdata, 11'h000);

      // Latency: change driven after edge N
      in_port = 11'h003;
      rd(2'd0); chk("data_n1", readdata, 11'h000);
      rd(2'd0); chk("data_n2", readdata, 11'h000);
      rd(2'd3); chk("cap_n3", readdata, 11'h000);
      rd(2'd3); chk("cap_n4", readdata, 11'h003);
      rd(2'd0); chk("data_n5", readdata, 11'h003);
      chk("irq_mask0", 11'(irq), 11'h000);

      // Partial W1C
      wr(2'd3, 11'h001);
      rd(2'd3); chk("cap_w1c_bit0", readdata, 11'h002);

`ifdef RAM_ADDR_PIO_IRQ_EN
      wr(2'd2, 11'h001);
`endif
      // Set-wins collision on bit0
      in_port = 11'h002;
      repeat (4) tick();
      rd(2'd3); chk("cap_bit0_set", readdata, 11'h003);
      in_port = 11'h003;
      tick(); tick();
      wr(2'd3, 11'h001);
`ifdef RAM_ADDR_PIO_IRQ_EN
      chk("irq_set_wins", 11'(irq), 11'h001);
`endif
      rd(2'd3); chk("cap_set_wins", readdata, 11'h003);

      // Reserved and read-only offsets
      rd(2'd1); chk("rsvd_read", readdata, 11'h000);
      wr(2'd1, 11'h7FF);
      rd(2'd1); chk("rsvd_after_wr", readdata, 11'h000);
      wr(2'd0, 11'h7FF);
      rd(2'd0); chk("data_ro", readdata, 11'h003);

      // Offset 2
      wr(2'd2, 11'h7FF);
`ifdef RAM_ADDR_PIO_IRQ_EN
      rd(2'd2); chk("mask_rw", readdata, 11'h7FF);
      chk("irq_mask_all", 11'(irq), 11'h001);
      wr(2'd2, 11'h000);
      chk("irq_mask_off", 11'(irq), 11'h000);
      wr(2'd2, 11'h002);
      chk("irq_mask_bit1", 11'(irq), 11'h001);
`else
      rd(2'd2); chk("mask_absent", readdata, 11'h000);
      chk("irq_tied0", 11'(irq), 11'h000);
`endif

      // Simultaneous read and write returns the pre-write value
      address = 2'd3; writedata = 11'h7FF; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
      tick();
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      chk("rw_collide_rd", readdata, 11'h003);
      rd(2'd3); chk("rw_collide_wr", readdata, 11'h000);
      chk("irq_after_clr", 11'(irq), 11'h000);

      // Interrupt flow on bit0
`ifdef RAM_ADDR_PIO_IRQ_EN
      wr(2'd2, 11'h001);
`endif
      in_port = 11'h002;
      tick(); tick();
      chk("irq_n2", 11'(irq), 11'h000);
      tick();
`ifdef RAM_ADDR_PIO_IRQ_EN
      chk("irq_n3", 11'(irq), 11'h001);
`else
      chk("irq_n3_off", 11'(irq), 11'h000);
`endif
      rd(2'd3); chk("cap_irq_src", readdata, 11'h001);
      wr(2'd3, 11'h001);
      chk("irq_w1c", 11'(irq), 11'h000);
      rd(2'd3); chk("cap_w1c_irq", readdata, 11'h000);

      // Mid-operation reset drops pending captures
      in_port = 11'h000;
      repeat (4) tick();
      rd(2'd3); chk("cap_pending", readdata, 11'h002);
`ifdef RAM_ADDR_PIO_IRQ_EN
      wr(2'd2, 11'h002);
      chk("irq_pending", 11'(irq), 11'h001);
`endif
      reset_n = 1'b0;
      tick();
      chk("midrst_readdata", readdata, 11'h000);
      chk("midrst_irq", 11'(irq), 11'h000);
      reset_n = 1'b1;
      repeat (4) tick();
      rd(2'd3); chk("midrst_cap", readdata, 11'h000);
      rd(2'd2); chk("midrst_mask", readdata, 11'h000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
